// File: rtl/incubator_ctrl.sv
// Incubator climate controller: dwell-gated IDLE/HEAT/COOL FSM, stepped cooling fan, sticky over-temp alarm.
// Latency: outputs follow the temperature sample by one clk edge (all decoded from registered state).
// Backpressure: none; t is sampled every cycle and alarm_clr is a single-cycle strobe.
module incubator_ctrl #(
    parameter int TW         = 8,
    parameter int LO_ON      = 15,
    parameter int HEAT_OFF   = 30,
    parameter int HI_ON      = 35,
    parameter int COOL_OFF   = 25,
    parameter int FAN_LEVELS = 3,
    parameter int FAN_STEP   = 5,
    parameter int CRS_BASE   = 4,
    parameter int CRS_INC    = 2,
    parameter int CRS_W      = 4,
    parameter int MIN_DWELL  = 4,
    parameter int ALARM_HI   = 50,
    parameter int ALARM_CNT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TW-1:0]    t,
    input  logic             alarm_clr,
    output logic             heater,
    output logic             cooler,
    output logic [CRS_W-1:0] crs,
    output logic [1:0]       mode,
    output logic             alarm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COOL = 2'd1,
        HEAT = 2'd2
    } mode_t;

    // Four guard bits keep HI_ON + k*FAN_STEP from wrapping.
    localparam int XW = TW + 4;
    localparam logic [XW-1:0] LO_ON_X    = XW'(LO_ON);
    localparam logic [XW-1:0] HEAT_OFF_X = XW'(HEAT_OFF);
    localparam logic [XW-1:0] HI_ON_X    = XW'(HI_ON);
    localparam logic [XW-1:0] COOL_OFF_X = XW'(COOL_OFF);
    localparam logic [XW-1:0] STEP_X     = XW'(FAN_STEP);
    localparam logic [XW-1:0] ALARM_HI_X = XW'(ALARM_HI);
    localparam logic [7:0]    DW_MAX     = 8'(MIN_DWELL);
    localparam logic [7:0]    ACNT_MAX   = 8'(ALARM_CNT);
    localparam logic [2:0]    LVL_MAX    = 3'(FAN_LEVELS);
    localparam int            CRS_MAX    = (1 << CRS_W) - 1;

    mode_t         state, state_nxt;
    logic [7:0]    dwell, dwell_nxt;
    logic [2:0]    level, level_nxt;
    logic [7:0]    acnt, acnt_nxt;
    logic          alarm_q, alarm_nxt;
    logic [XW-1:0] tx, thr_up, thr_dn;
    int            crs_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dwell   <= DW_MAX;
            level   <= 3'd0;
            acnt    <= 8'd0;
            alarm_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            dwell   <= dwell_nxt;
            level   <= level_nxt;
            acnt    <= acnt_nxt;
            alarm_q <= alarm_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell;
        level_nxt = level;
        tx        = XW'(t);
        thr_up    = HI_ON_X + XW'(level) * STEP_X;
        thr_dn    = HI_ON_X + ((level >= 3'd2) ? XW'(level - 3'd2) : '0) * STEP_X;

        if (dwell == DW_MAX) begin
            case (state)
                IDLE: begin
                    if (tx < LO_ON_X)      state_nxt = HEAT;
                    else if (tx > HI_ON_X) state_nxt = COOL;
                end
                HEAT: if (tx > HEAT_OFF_X) state_nxt = IDLE;
                COOL: if (tx < COOL_OFF_X && level == 3'd1) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        if (state_nxt != state)  dwell_nxt = 8'd0;
        else if (dwell < DW_MAX) dwell_nxt = dwell + 8'd1;

        // Fan steps freely while cooling; only mode changes are dwell-gated.
        if (state_nxt != COOL) begin
            level_nxt = 3'd0;
        end else if (state != COOL) begin
            level_nxt = 3'd1;
        end else if (level < LVL_MAX && tx > thr_up) begin
            level_nxt = level + 3'd1;
        end else if (level >= 3'd2 && tx < thr_dn) begin
            level_nxt = level - 3'd1;
        end
    end

    always_comb begin
        acnt_nxt  = 8'd0;
        alarm_nxt = alarm_q;
        if (alarm_clr) begin
            alarm_nxt = 1'b0;
        end else if (tx > ALARM_HI_X) begin
            acnt_nxt  = (acnt == ACNT_MAX) ? acnt : acnt + 8'd1;
            alarm_nxt = alarm_q | (acnt_nxt == ACNT_MAX);
        end
    end

    always_comb begin
        crs_raw = CRS_BASE + (int'(level) - 1) * CRS_INC;
        if (level == 3'd0)          crs = '0;
        else if (crs_raw > CRS_MAX) crs = CRS_W'(CRS_MAX);
        else                        crs = CRS_W'(crs_raw);
    end

    assign mode   = state;
    assign heater = (state == HEAT);
    assign cooler = (state == COOL);
    assign alarm  = alarm_q;

endmodule

// File: tb/tb_incubator_ctrl.sv
// Bench for incubator_ctrl: directed per-edge vectors feed a scoreboard queue, a monitor checks each edge.
// Latency: each vector's expectation applies to the outputs just after the edge that samples it.
// Backpressure: none; the monitor pops one entry per clock edge while the queue is non-empty.
module tb_incubator_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] t = 8'd0;
    logic       alarm_clr = 1'b0;
    logic       heater, cooler, alarm;
    logic [3:0] crs;
    logic [1:0] mode;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [3:0] crs;
        logic       alarm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    incubator_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .t         (t),
        .alarm_clr (alarm_clr),
        .heater    (heater),
        .cooler    (cooler),
        .crs       (crs),
        .mode      (mode),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic r, input logic [7:0] tv, input logic c,
                        input logic [1:0] em, input logic [3:0] ec, input logic ea);
        exp_t e;
        @(negedge clk);
        rst = r;
        t = tv;
        alarm_clr = c;
        e.name = nm;
        e.mode = em;
        e.crs = ec;
        e.alarm = ea;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: one expectation per edge, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        logic [8:0] act, req;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {mode, heater, cooler, crs, alarm};
                req = {e.mode, (e.mode == 2'd2), (e.mode == 2'd1), e.crs, e.alarm};
                total++;
                if (act !== req) begin
                    bad++;
                    $display("FAIL %s: got mode=%0d heater=%0b cooler=%0b crs=%0d alarm=%0b, want mode=%0d heater=%0b cooler=%0b crs=%0d alarm=%0b",
                             e.name, act[8:7], act[6], act[5], act[4:1], act[0],
                             req[8:7], req[6], req[5], req[4:1], req[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Reset with hot input, then cooling ramp up and back down to IDLE.
        step("rst_a0",     1, 50, 0, 0, 0, 0);
        step("rst_a1",     1, 50, 0, 0, 0, 0);
        step("cool_entry", 0, 50, 0, 1, 4, 0);
        step("fan_up2",    0, 50, 0, 1, 6, 0);
        step("fan_up3",    0, 50, 0, 1, 8, 0);
        step("fan_dn2",    0, 20, 0, 1, 6, 0);
        step("fan_dn1",    0, 20, 0, 1, 4, 0);
        step("cool_exit",  0, 20, 0, 0, 0, 0);

        // Fan threshold equality, then reset mid-COOL at level 3.
        step("rst_b",      1, 50, 0, 0, 0, 0);
        step("cool_b",     0, 50, 0, 1, 4, 0);
        step("fan_eq40",   0, 40, 0, 1, 4, 0);
        step("fan_41",     0, 41, 0, 1, 6, 0);
        step("fan_b3",     0, 50, 0, 1, 8, 0);
        step("rst_midcool",1, 50, 0, 0, 0, 0);
        step("idle_30",    0, 30, 0, 0, 0, 0);

        // Heating with dwell-gated exit.
        step("rst_c",      1, 10, 0, 0, 0, 0);
        step("heat_e1",    0, 10, 0, 2, 0, 0);
        step("heat_e2",    0, 31, 0, 2, 0, 0);
        step("heat_e3",    0, 31, 0, 2, 0, 0);
        step("heat_e4",    0, 31, 0, 2, 0, 0);
        step("heat_e5",    0, 31, 0, 2, 0, 0);
        step("heat_drop6", 0, 31, 0, 0, 0, 0);
        step("idle_31",    0, 31, 0, 0, 0, 0);

        // Anti-chatter: brief excursion above HEAT_OFF while dwell is short.
        step("rst_d",      1, 10, 0, 0, 0, 0);
        step("heat_d0",    0, 10, 0, 2, 0, 0);
        step("heat_d1",    0, 10, 0, 2, 0, 0);
        step("chat_31a",   0, 31, 0, 2, 0, 0);
        step("chat_31b",   0, 31, 0, 2, 0, 0);
        step("chat_12a",   0, 12, 0, 2, 0, 0);
        step("chat_12b",   0, 12, 0, 2, 0, 0);
        step("heat_eq30",  0, 30, 0, 2, 0, 0);
        step("heat_off31", 0, 31, 0, 0, 0, 0);
        step("idle_eq15a", 0, 15, 0, 0, 0, 0);
        step("idle_eq15b", 0, 15, 0, 0, 0, 0);
        step("idle_eq15c", 0, 15, 0, 0, 0, 0);
        step("idle_eq15d", 0, 15, 0, 0, 0, 0);
        step("idle_eq35",  0, 35, 0, 0, 0, 0);
        step("idle_14",    0, 14, 0, 2, 0, 0);

        // Alarm persistence, sticky hold, clear, and clear-over-set.
        step("rst_e",      1, 20, 0, 0, 0, 0);
        step("alm_55a",    0, 55, 0, 1, 4, 0);
        step("alm_55b",    0, 55, 0, 1, 6, 0);
        step("alm_45",     0, 45, 0, 1, 6, 0);
        step("alm_55c",    0, 55, 0, 1, 8, 0);
        step("alm_55d",    0, 55, 0, 1, 8, 0);
        step("alm_set",    0, 55, 0, 1, 8, 1);
        step("alm_hold20", 0, 20, 0, 1, 6, 1);
        step("alm_hold2",  0, 20, 0, 1, 4, 1);
        step("alm_clr",    0, 20, 1, 0, 0, 0);
        step("clr_held0",  0, 55, 1, 0, 0, 0);
        step("clr_held1",  0, 55, 1, 0, 0, 0);
        step("clr_held2",  0, 55, 1, 0, 0, 0);
        step("clr_held3",  0, 55, 1, 0, 0, 0);
        step("alm_re1",    0, 55, 0, 1, 4, 0);
        step("alm_re2",    0, 55, 0, 1, 6, 0);
        step("clr_wins",   0, 55, 1, 1, 8, 0);
        step("alm_after",  0, 55, 0, 1, 8, 0);

        @(negedge clk);
        rst = 1'b0;
        alarm_clr = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/incubator_ctrl.md
INCUBATOR_CTRL -- requirements
Module: incubator_ctrl

Interface
REQ-001 SHALL have parameter TW, default 8: temperature width, unsigned.
REQ-002 SHALL have parameter LO_ON, default 15: heating starts below this temperature.
REQ-003 SHALL have parameter HEAT_OFF, default 30: heating stops above this temperature.
REQ-004 SHALL have parameter HI_ON, default 35: cooling starts above this temperature.
REQ-005 SHALL have parameter COOL_OFF, default 25: cooling stops below this temperature.
REQ-006 SHALL have parameter FAN_LEVELS, default 3: highest fan level (2..7).
REQ-007 SHALL have parameter FAN_STEP, default 5: temperature spacing between fan thresholds.
REQ-008 SHALL have parameters CRS_BASE and CRS_INC, defaults 4 and 2: fan speed at level 1, and the increment per additional level.
REQ-009 SHALL have parameter CRS_W, default 4: fan speed output width.
REQ-010 SHALL have parameter MIN_DWELL, default 4: minimum cycles spent in a mode before leaving it (1..255).
REQ-011 SHALL have parameters ALARM_HI and ALARM_CNT, defaults 50 and 3: over-temperature threshold and its persistence count.
REQ-012 SHALL have ports as follows:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- t  in  TW  sampled temperature, unsigned.
- alarm_clr  in  1  single-cycle clear of the sticky alarm.
- heater  out  1  heater on.
- cooler  out  1  cooler on.
- crs  out  CRS_W  fan speed.
- mode  out  2  mode: 0=IDLE, 1=COOL, 2=HEAT.
- alarm  out  1  sticky over-temperature alarm.

Function
REQ-013 SHALL run a mode FSM with states IDLE, HEAT and COOL.
REQ-014 SHALL drive all outputs from registered state only: heater=(mode==HEAT), cooler=(mode==COOL).
REQ-015 SHALL keep a dwell counter that clears to 0 on every mode change, increments each cycle otherwise, and saturates at MIN_DWELL.
REQ-016 SHALL take a mode transition only on an edge where dwell==MIN_DWELL and the transition condition holds.
REQ-017 SHALL use these IDLE exits, with HEAT taking priority:
- t<LO_ON -> HEAT.
- t>HI_ON -> COOL.
REQ-018 SHALL exit HEAT -> IDLE when t>HEAT_OFF.
REQ-019 SHALL exit COOL -> IDLE only when t<COOL_OFF and fan level==1.
REQ-020 SHALL manage the fan level as follows:
- level is 0 outside COOL.
- level is set to 1 on entry to COOL.
- level is forced to 0 on exit from COOL.
REQ-021 SHALL step the fan level in COOL by at most one level per cycle, regardless of dwell:
- level k < FAN_LEVELS -> k+1 when t > HI_ON + k*FAN_STEP.
- level k >= 2 -> k-1 when t < HI_ON + (k-2)*FAN_STEP.
REQ-022 SHALL compute threshold sums at TW+4 bits with no wrap.
REQ-023 SHALL drive crs=0 at level 0, otherwise CRS_BASE+(level-1)*CRS_INC, saturated at 2^CRS_W-1.
REQ-024 SHALL count consecutive cycles with t>ALARM_HI, clearing the count on any cycle with t<=ALARM_HI and saturating at ALARM_CNT.
REQ-025 SHALL set alarm when the count reaches ALARM_CNT, and hold alarm until alarm_clr.
REQ-026 SHALL, when alarm_clr is asserted, clear both alarm and the count on that edge; clear wins over set in the same cycle.
REQ-027 SHALL leave alarm without effect on mode control.
REQ-028 SHALL compare all temperatures strictly (< and >); equality causes no transition.

Reset
REQ-029 SHALL, with rst high at an edge, set mode=IDLE, level=0, dwell=MIN_DWELL (IDLE treated as settled), alarm count=0 and alarm=0.
REQ-030 SHALL therefore hold heater=0, cooler=0, crs=0, mode=0 and alarm=0 after reset.
REQ-031 SHALL have rst take priority over all other inputs, including mid-COOL and mid-dwell.

Verification (default parameters)
REQ-032 SHALL cover: rst high 2 cycles with t=50 -> all outputs 0; the first edge after release with t=50 -> mode=1, cooler=1, crs=4.
REQ-033 SHALL cover: from reset, t=10 -> heater=1 after edge 1; then t=31 -> heater stays 1 through edge 5 and drops at edge 6 (dwell).
REQ-034 SHALL cover: in HEAT at dwell 1, t=31 for 2 cycles then t=12 -> heater never drops (anti-chatter).
REQ-035 SHALL cover: t=50 from IDLE -> crs 4, 6, 8 on successive edges; then t=20 -> crs 6, 4, then 0 with mode=IDLE.
REQ-036 SHALL cover alarm persistence and clear:
- t=55 for 2 cycles then 45 -> alarm stays 0.
- t=55 for 3 cycles -> alarm=1, which persists at t=20.
- alarm_clr pulse -> alarm=0.
- alarm_clr held with t=55 -> alarm stays 0.
REQ-037 SHALL cover: in COOL at level 3, assert rst for one cycle -> next cycle mode=0, crs=0, cooler=0.
